// File: rtl/kpn_pkg.sv
// Shared definitions for the KPN datapath stages (merge, split, join).
// Token width, counter width and the input-select encoding live here.
package kpn_pkg;

  localparam int unsigned KPN_DATA_W  = 16;
  localparam int unsigned KPN_CNT_W   = 16;
  localparam int unsigned KPN_BURST_W = 8;

  typedef enum logic {
    SEL_A = 1'b0,
    SEL_B = 1'b1
  } sel_e;

  function automatic sel_e sel_flip(input sel_e s);
    return (s == SEL_A) ? SEL_B : SEL_A;
  endfunction

endpackage

// File: rtl/kpn_out_stage.sv
// One-entry valid/ready output register shared by the KPN stages.
// A load may coincide with the downstream handshake, giving 1 token/clk.
module kpn_out_stage #(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              out_rdy,
  output logic [DATA_W-1:0] out_data,
  output logic              out_vld,
  output logic              free,
  output logic              emit
);

  logic [DATA_W-1:0] data_q;
  logic              vld_q;

  assign free     = !vld_q | out_rdy;
  assign emit     = vld_q & out_rdy;
  assign out_data = data_q;
  assign out_vld  = vld_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q <= '0;
      vld_q  <= 1'b0;
    end else if (load) begin
      data_q <= load_data;
      vld_q  <= 1'b1;
    end else if (out_rdy) begin
      vld_q  <= 1'b0;
    end
  end

endmodule

// File: rtl/merge_module.sv
// Deterministic two-into-one KPN merge: BURST_LEN tokens from A, then from B.
// The unselected input is never taken, so the output order is timing-independent.
module merge_module
  import kpn_pkg::*;
#(
  parameter int unsigned DATA_W    = KPN_DATA_W,
  parameter int unsigned BURST_LEN = 1,
  parameter int unsigned START_B   = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_W-1:0]    entry_1,
  input  logic                 entry_1_vld,
  output logic                 entry_1_rdy,
  input  logic [DATA_W-1:0]    entry_2,
  input  logic                 entry_2_vld,
  output logic                 entry_2_rdy,
  output logic [DATA_W-1:0]    output_1,
  output logic                 output_1_vld,
  input  logic                 output_1_rdy,
  output logic [KPN_CNT_W-1:0] token_cnt
);

  localparam logic [KPN_BURST_W-1:0] BurstLast = KPN_BURST_W'(BURST_LEN - 1);
  localparam sel_e SelInit = (START_B != 0) ? SEL_B : SEL_A;

  sel_e                   sel_q;
  logic [KPN_BURST_W-1:0] burst_q;
  logic [KPN_CNT_W-1:0]   token_cnt_q;
  logic                   free;
  logic                   emit;
  logic                   accept;
  logic [DATA_W-1:0]      sel_data;

  // Ready is gated by reset so nothing is consumed while the stage is held.
  assign entry_1_rdy = (sel_q == SEL_A) & free & rst_n;
  assign entry_2_rdy = (sel_q == SEL_B) & free & rst_n;

  assign accept   = (sel_q == SEL_A) ? (entry_1_vld & entry_1_rdy)
                                     : (entry_2_vld & entry_2_rdy);
  assign sel_data = (sel_q == SEL_A) ? entry_1 : entry_2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_q   <= SelInit;
      burst_q <= '0;
    end else if (accept) begin
      if (burst_q == BurstLast) begin
        burst_q <= '0;
        sel_q   <= sel_flip(sel_q);
      end else begin
        burst_q <= burst_q + KPN_BURST_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      token_cnt_q <= '0;
    end else if (emit) begin
      token_cnt_q <= token_cnt_q + KPN_CNT_W'(1);
    end
  end

  assign token_cnt = token_cnt_q;

  kpn_out_stage #(
    .DATA_W (DATA_W)
  ) u_out_stage (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (accept),
    .load_data (sel_data),
    .out_rdy   (output_1_rdy),
    .out_data  (output_1),
    .out_vld   (output_1_vld),
    .free      (free),
    .emit      (emit)
  );

endmodule

// File: tb/tb_merge_module.sv
// Directed bench for merge_module: three instances with BURST_LEN 1, 2 and 3
// share one stimulus set; each test checks the instance it targets.
module tb_merge_module;

  logic        clk;
  logic        rst_n;
  logic [15:0] a;
  logic        av;
  logic [15:0] b;
  logic        bv;
  logic        ordy;

  logic [15:0] o_data [3];
  logic        o_vld  [3];
  logic        e1r    [3];
  logic        e2r    [3];
  logic [15:0] cnt    [3];

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        rst;
    logic [15:0] a;
    logic        av;
    logic [15:0] b;
    logic        bv;
    logic        ordy;
    logic        ea;
    logic        eb;
    logic [15:0] eo;
    logic        ev;
    logic [15:0] ec;
  } vec_t;

  vec_t vq[$];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    merge_module #(
      .DATA_W    (16),
      .BURST_LEN (g + 1),
      .START_B   (0)
    ) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .entry_1      (a),
      .entry_1_vld  (av),
      .entry_1_rdy  (e1r[g]),
      .entry_2      (b),
      .entry_2_vld  (bv),
      .entry_2_rdy  (e2r[g]),
      .output_1     (o_data[g]),
      .output_1_vld (o_vld[g]),
      .output_1_rdy (ordy),
      .token_cnt    (cnt[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [15:0] a_, input logic av_,
                     input logic [15:0] b_, input logic bv_, input logic ordy_,
                     input logic ea_, input logic eb_, input logic [15:0] eo_,
                     input logic ev_, input logic [15:0] ec_);
    vec_t t;
    t.rst = r;  t.a = a_;   t.av = av_; t.b = b_;   t.bv = bv_; t.ordy = ordy_;
    t.ea  = ea_; t.eb = eb_; t.eo = eo_; t.ev = ev_; t.ec = ec_;
    vq.push_back(t);
  endtask

  // Inputs change on negedge; checks sample #1 later, well clear of posedge.
  task automatic run_table(input int d, input string tag);
    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      rst_n = vq[i].rst;
      a     = vq[i].a;
      av    = vq[i].av;
      b     = vq[i].b;
      bv    = vq[i].bv;
      ordy  = vq[i].ordy;
      #1;
      chk($sformatf("%s[%0d] entry_1_rdy", tag, i), 16'(e1r[d]), 16'(vq[i].ea));
      chk($sformatf("%s[%0d] entry_2_rdy", tag, i), 16'(e2r[d]), 16'(vq[i].eb));
      chk($sformatf("%s[%0d] output_1_vld", tag, i), 16'(o_vld[d]), 16'(vq[i].ev));
      chk($sformatf("%s[%0d] output_1", tag, i), o_data[d], vq[i].eo);
      chk($sformatf("%s[%0d] token_cnt", tag, i), cnt[d], vq[i].ec);
    end
    vq.delete();
  endtask

  task automatic reset_all();
    @(negedge clk);
    rst_n = 1'b0;
    av    = 1'b0;
    bv    = 1'b0;
    ordy  = 1'b1;
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic found;
    logic gap;

    rst_n = 1'b0;
    a = 16'h0; av = 1'b1; b = 16'h0; bv = 1'b1; ordy = 1'b1;

    // Reset held for 3 clocks with both inputs valid.
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset dut%0d output_1_vld", d), 16'(o_vld[d]), 16'h0);
      chk($sformatf("reset dut%0d token_cnt", d), cnt[d], 16'h0);
      chk($sformatf("reset dut%0d entry_1_rdy", d), 16'(e1r[d]), 16'h0);
      chk($sformatf("reset dut%0d entry_2_rdy", d), 16'(e2r[d]), 16'h0);
      chk($sformatf("reset dut%0d output_1", d), o_data[d], 16'h0);
    end

    // BURST_LEN=1 alternation A,B,A,B... at full rate.
    reset_all();
    add(1, 16'd1, 1, 16'd10, 1, 1, 1, 0, 16'd0,  0, 16'd0);
    add(1, 16'd2, 1, 16'd10, 1, 1, 0, 1, 16'd1,  1, 16'd0);
    add(1, 16'd2, 1, 16'd20, 1, 1, 1, 0, 16'd10, 1, 16'd1);
    add(1, 16'd3, 1, 16'd20, 1, 1, 0, 1, 16'd2,  1, 16'd2);
    add(1, 16'd3, 1, 16'd30, 1, 1, 1, 0, 16'd20, 1, 16'd3);
    add(1, 16'd0, 0, 16'd30, 1, 1, 0, 1, 16'd3,  1, 16'd4);
    add(1, 16'd0, 0, 16'd0,  0, 1, 1, 0, 16'd30, 1, 16'd5);
    add(1, 16'd0, 0, 16'd0,  0, 1, 1, 0, 16'd30, 0, 16'd6);
    run_table(0, "alt");

    // BURST_LEN=2: idle A blocks B; then A sends 4,5 and B's 7 follows.
    reset_all();
    for (int i = 0; i < 5; i++) add(1, 16'd0, 0, 16'd7, 1, 1, 1, 0, 16'd0, 0, 16'd0);
    add(1, 16'd4, 1, 16'd7, 1, 1, 1, 0, 16'd0, 0, 16'd0);
    add(1, 16'd5, 1, 16'd7, 1, 1, 1, 0, 16'd4, 1, 16'd0);
    add(1, 16'd0, 0, 16'd7, 1, 1, 0, 1, 16'd5, 1, 16'd1);
    add(1, 16'd0, 0, 16'd0, 0, 1, 0, 1, 16'd7, 1, 16'd2);
    add(1, 16'd0, 0, 16'd0, 0, 1, 0, 1, 16'd7, 0, 16'd3);
    run_table(1, "block");

    // Backpressure holding 0x00AA for 4 clocks.
    reset_all();
    add(1, 16'h00AA, 1, 16'h0055, 1, 1, 1, 0, 16'h0000, 0, 16'd0);
    for (int i = 0; i < 4; i++)
      add(1, 16'h0000, 0, 16'h0055, 1, 0, 0, 0, 16'h00AA, 1, 16'd0);
    add(1, 16'h0000, 0, 16'h0055, 1, 1, 0, 1, 16'h00AA, 1, 16'd0);
    add(1, 16'h0000, 0, 16'h0000, 0, 1, 1, 0, 16'h0055, 1, 16'd1);
    add(1, 16'h0000, 0, 16'h0000, 0, 1, 1, 0, 16'h0055, 0, 16'd2);
    run_table(0, "bp");

    // BURST_LEN=3 reset after two A tokens: held token dropped, A restarts.
    reset_all();
    add(1, 16'd1, 1, 16'd9, 1, 1, 1, 0, 16'd0, 0, 16'd0);
    add(1, 16'd2, 1, 16'd9, 1, 1, 1, 0, 16'd1, 1, 16'd0);
    add(0, 16'd3, 1, 16'd9, 1, 1, 0, 0, 16'd2, 1, 16'd1);
    add(1, 16'd3, 1, 16'd9, 1, 1, 1, 0, 16'd0, 0, 16'd0);
    add(1, 16'd4, 1, 16'd9, 1, 1, 1, 0, 16'd3, 1, 16'd0);
    add(1, 16'd5, 1, 16'd9, 1, 1, 1, 0, 16'd4, 1, 16'd1);
    add(1, 16'd0, 0, 16'd9, 1, 1, 0, 1, 16'd5, 1, 16'd2);
    add(1, 16'd0, 0, 16'd0, 0, 1, 0, 1, 16'd9, 1, 16'd3);
    run_table(2, "midrst");

    // Counter wrap under continuous streaming on the BURST_LEN=1 instance.
    reset_all();
    @(negedge clk);
    rst_n = 1'b1; a = 16'd1; av = 1'b1; b = 16'd2; bv = 1'b1; ordy = 1'b1;
    found = 1'b0;
    gap   = 1'b0;
    for (int i = 0; i < 70000 && !found; i++) begin
      @(negedge clk);
      #1;
      if (!o_vld[0]) gap = 1'b1;
      if (cnt[0] == 16'hFFFF) found = 1'b1;
    end
    chk("wrap reached 0xFFFF", 16'(found), 16'h1);
    chk("wrap stream vld gap", 16'(gap), 16'h0);
    chk("wrap vld before", 16'(o_vld[0]), 16'h1);
    @(negedge clk);
    #1;
    chk("wrap token_cnt", cnt[0], 16'h0000);
    chk("wrap vld after", 16'(o_vld[0]), 16'h1);
    @(negedge clk);
    #1;
    chk("wrap token_cnt +1", cnt[0], 16'h0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
